// File: rtl/serializer_piso.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_piso
//  Description : Parallel-in / serial-out shifter with a three-state
//                IDLE -> SHIFT -> DONE frame sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module serializer_piso #(
    parameter int DATA_WIDTH = 8,     // parallel word width, 2..32
    parameter bit MSB_FIRST  = 1'b1   // 1: bit DATA_WIDTH-1 first, 0: bit 0 first
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  LOAD,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] BUFF,
    output logic                  serial_out,
    output logic                  shift,
    output logic                  TX_active,
    output logic                  ready,
    output logic                  done
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   buff_q,  buff_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic                    serial_q, serial_d;

    // Shift-register contents after one shift toward the output end, and the
    // bit that will sit at the output end of the next register value.
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic                    w_head_d;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {buff_q[DATA_WIDTH-2:0], 1'b0};
            assign w_head_d  = buff_d[DATA_WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, buff_q[DATA_WIDTH-1:1]};
            assign w_head_d  = buff_d[0];
        end
    endgenerate

    // serial_out is registered: it carries the head bit only while the next
    // state is SHIFT, so it is 0 in IDLE/DONE and right after reset.
    assign serial_d = (state_d == ST_SHIFT) ? w_head_d : 1'b0;

    // State, shift register, bit counter and serial output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            buff_q   <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buff_q   <= buff_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_d   = state_q;
        buff_d    = buff_q;
        cnt_d     = cnt_q;
        shift     = 1'b0;
        TX_active = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                // LOAD only matters here; requests in SHIFT/DONE are dropped.
                if (LOAD) begin
                    buff_d  = DATA_IN;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift     = 1'b1;
                TX_active = 1'b1;
                buff_d    = w_shifted;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUFF       = buff_q;
    assign serial_out = serial_q;

endmodule
`default_nettype wire

// File: tb/tb_serializer_piso.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serializer_piso
//  Description : Self-checking bench for serializer_piso, running an
//                MSB-first and an LSB-first instance side by side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serializer_piso;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] din;

    logic [W-1:0] buff_m, buff_l;
    logic         so_m, so_l, sh_m, sh_l, tx_m, tx_l, rdy_m, rdy_l, dn_m, dn_l;

    int checks = 0;
    int passed = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    serializer_piso #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .LOAD(load), .DATA_IN(din), .BUFF(buff_m),
        .serial_out(so_m), .shift(sh_m), .TX_active(tx_m), .ready(rdy_m), .done(dn_m)
    );

    serializer_piso #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .LOAD(load), .DATA_IN(din), .BUFF(buff_l),
        .serial_out(so_l), .shift(sh_l), .TX_active(tx_l), .ready(rdy_l), .done(dn_l)
    );

    // Reference frame sequencer: pushes the expected bit stream on every
    // accepted LOAD and flushes it on reset.
    typedef enum {M_IDLE, M_SHIFT, M_DONE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_cnt   = 0;
    bit      exp_m[$];
    bit      exp_l[$];

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            exp_m.delete();
            exp_l.delete();
        end else begin
            case (m_state)
                M_IDLE: if (load === 1'b1) begin
                    for (int i = 0; i < W; i++) begin
                        exp_m.push_back(din[W-1-i]);
                        exp_l.push_back(din[i]);
                    end
                    m_state = M_SHIFT;
                    m_cnt   = 0;
                end
                M_SHIFT: begin
                    m_cnt++;
                    if (m_cnt == W) m_state = M_DONE;
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    // Cycle monitor: status flags against the reference and serial bits
    // popped from the scoreboard queues.
    logic [3:0] e_ctrl;
    bit         e_bit;
    always @(negedge clk) begin
        if (mon_en) begin
            e_ctrl = {m_state == M_SHIFT, m_state == M_SHIFT,
                      m_state == M_IDLE,  m_state == M_DONE};
            checks++;
            if ({sh_m, tx_m, rdy_m, dn_m} !== e_ctrl)
                $display("FAIL ctrl_msb t=%0t: got %b expected %b (shift,tx,ready,done)",
                         $time, {sh_m, tx_m, rdy_m, dn_m}, e_ctrl);
            else passed++;
            checks++;
            if ({sh_l, tx_l, rdy_l, dn_l} !== e_ctrl)
                $display("FAIL ctrl_lsb t=%0t: got %b expected %b (shift,tx,ready,done)",
                         $time, {sh_l, tx_l, rdy_l, dn_l}, e_ctrl);
            else passed++;
            if (m_state == M_SHIFT) begin
                checks++;
                if (exp_m.size() == 0) $display("FAIL sb_msb t=%0t: got underflow expected data", $time);
                else begin
                    e_bit = exp_m.pop_front();
                    if (so_m !== e_bit) $display("FAIL serial_msb t=%0t: got %b expected %b", $time, so_m, e_bit);
                    else passed++;
                end
                checks++;
                if (exp_l.size() == 0) $display("FAIL sb_lsb t=%0t: got underflow expected data", $time);
                else begin
                    e_bit = exp_l.pop_front();
                    if (so_l !== e_bit) $display("FAIL serial_lsb t=%0t: got %b expected %b", $time, so_l, e_bit);
                    else passed++;
                end
            end else begin
                checks++;
                if ({so_m, so_l} !== 2'b00)
                    $display("FAIL serial_idle t=%0t: got %b expected 00", $time, {so_m, so_l});
                else passed++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        load = 1'b0;
        din  = '0;
        repeat (3) tick();
        checks++;
        if ({rdy_m, sh_m, tx_m, dn_m, so_m, buff_m} !== {5'b10000, 8'h00})
            $display("FAIL reset_msb: got %b expected %b", {rdy_m, sh_m, tx_m, dn_m, so_m, buff_m}, {5'b10000, 8'h00});
        else passed++;
        checks++;
        if ({rdy_l, sh_l, tx_l, dn_l, so_l, buff_l} !== {5'b10000, 8'h00})
            $display("FAIL reset_lsb: got %b expected %b", {rdy_l, sh_l, tx_l, dn_l, so_l, buff_l}, {5'b10000, 8'h00});
        else passed++;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_a5;
        din  = 8'hA5;
        load = 1'b1;
        tick();                       // accepting edge
        load = 1'b0;
        din  = 8'hFF;                 // must not disturb the frame
        checks++;
        if (buff_m !== 8'hA5) $display("FAIL cap_msb: got %h expected a5", buff_m); else passed++;
        checks++;
        if (buff_l !== 8'hA5) $display("FAIL cap_lsb: got %h expected a5", buff_l); else passed++;
        tick();
        checks++;
        if (buff_m !== 8'h4A) $display("FAIL shift1_msb: got %h expected 4a", buff_m); else passed++;
        checks++;
        if (buff_l !== 8'h52) $display("FAIL shift1_lsb: got %h expected 52", buff_l); else passed++;
        repeat (6) tick();
        checks++;
        if ({sh_m, sh_l} !== 2'b11) $display("FAIL last_bit_shift: got %b expected 11", {sh_m, sh_l}); else passed++;
        tick();
        checks++;
        if ({dn_m, dn_l, rdy_m} !== 3'b110) $display("FAIL done_pulse: got %b expected 110", {dn_m, dn_l, rdy_m}); else passed++;
        tick();
        checks++;
        if ({dn_m, rdy_m, rdy_l} !== 3'b011) $display("FAIL back_idle: got %b expected 011", {dn_m, rdy_m, rdy_l}); else passed++;
        checks++;
        if (exp_m.size() + exp_l.size() != 0)
            $display("FAIL sb_drain: got %0d leftover bits expected 0", exp_m.size() + exp_l.size());
        else passed++;
    endtask

    task automatic test_pulsed_load;
        int ndone = 0;
        din = 8'h3C;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 10; c++) begin
                load = (c < 5);
                tick();
                if (dn_m === 1'b1) ndone++;
            end
        end
        load = 1'b0;
        repeat (4) begin
            tick();
            if (dn_m === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 3) $display("FAIL pulsed_frames: got %0d expected 3", ndone); else passed++;
    endtask

    task automatic test_back_to_back;
        int dones[$];
        load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = 8'($urandom);
            tick();
            if (dn_m === 1'b1) dones.push_back(i);
        end
        load = 1'b0;
        repeat (12) tick();
        checks++;
        if (dones.size() != 4) $display("FAIL b2b_count: got %0d expected 4", dones.size());
        else begin
            passed++;
            checks++;
            if (dones[0] != 8 || dones[1] != 18 || dones[2] != 28 || dones[3] != 38)
                $display("FAIL b2b_period: got %0d,%0d,%0d,%0d expected 8,18,28,38",
                         dones[0], dones[1], dones[2], dones[3]);
            else passed++;
        end
    endtask

    task automatic test_abort;
        int ndone = 0;
        din  = 8'hC3;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();            // bit 4 now on serial_out
        rst = 1'b1;
        tick();
        checks++;
        if ({rdy_m, sh_m, dn_m, so_m, buff_m, buff_l} !== {4'b1000, 16'h0000})
            $display("FAIL abort_state: got %b expected %b", {rdy_m, sh_m, dn_m, so_m, buff_m, buff_l}, {4'b1000, 16'h0000});
        else passed++;
        rst = 1'b0;
        repeat (12) begin
            tick();
            if ((dn_m | dn_l) === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) $display("FAIL abort_done: got %0d expected 0", ndone); else passed++;
    endtask

    task automatic test_rst_with_load;
        rst  = 1'b1;
        load = 1'b1;
        din  = 8'hFF;
        tick();
        checks++;
        if ({rdy_m, sh_m, buff_m} !== {2'b10, 8'h00})
            $display("FAIL rst_over_load: got %b expected %b", {rdy_m, sh_m, buff_m}, {2'b10, 8'h00});
        else passed++;
        rst = 1'b0;
        tick();                       // first edge with rst low accepts
        load = 1'b0;
        checks++;
        if ({sh_m, buff_m} !== {1'b1, 8'hFF})
            $display("FAIL first_load: got %b expected %b", {sh_m, buff_m}, {1'b1, 8'hFF});
        else passed++;
        repeat (10) tick();
        checks++;
        if (rdy_m !== 1'b1) $display("FAIL final_ready: got %b expected 1", rdy_m); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_a5();
        test_pulsed_load();
        test_back_to_back();
        test_abort();
        test_rst_with_load();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
